// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// divide-by-zero result constants.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  // Divide by zero: LO is all ones (sliced to the datapath width), HI is the dividend.
  localparam int unsigned   DivZeroMaxW = 64;
  localparam logic [DivZeroMaxW-1:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// With MULDIV_EARLY_OUT_EN defined, a zero divisor or dividend < divisor finishes in one cycle.
module muldiv_div_core #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(W);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic            last;
  logic            early;

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dsr_q};
    last    = (cnt_q == CntW'(W - 1));
`ifdef MULDIV_EARLY_OUT_EN
    // quo_q still holds the untouched dividend in the first iteration.
    early   = (cnt_q == '0) && ((dsr_q == '0) || (quo_q < dsr_q));
`else
    early   = 1'b0;
`endif
    // done_o flags that the result is final at the coming edge.
    done_o  = busy_q & (last | early);

    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;

    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend_i;
      dsr_d  = divisor_i;
    end else if (busy_q) begin
      if (early) begin
        busy_d = 1'b0;
        rem_d  = quo_q;
        quo_d  = '0;
      end else begin
        if (!diff[W]) begin
          rem_d = diff[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          busy_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= abort_i ? 1'b0 : busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
    end
  end

endmodule

// File: rtl/pipeline_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO, with valid/ready handshake and kill.
// MULDIV_EARLY_OUT_EN (in muldiv_div_core) enables the two-cycle short divide path.
module pipeline_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         req_ready,
  input  logic         kill,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out,
  output logic         busy,
  output logic         done,
  output logic         bad_op
);

  localparam int unsigned MulCntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic               done_q, done_d;
  logic               bad_op_q, bad_op_d;
  logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               mul_signed_q, mul_signed_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               b_zero_q, b_zero_d;

  logic               div_signed;
  logic [W-1:0]       a_mag;
  logic [W-1:0]       b_mag;
  logic               div_start;
  logic               div_done;
  logic [W-1:0]       div_quo;
  logic [W-1:0]       div_rem;
  logic [W-1:0]       fix_quo;
  logic [W-1:0]       fix_rem;
  logic [2*W-1:0]     a_ext;
  logic [2*W-1:0]     b_ext;
  logic [2*W-1:0]     prod;

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign done      = done_q;
  assign bad_op    = bad_op_q;

  assign div_signed = (req_op == OP_DIV);
  assign a_mag      = (div_signed && req_a[W-1]) ? -req_a : req_a;
  assign b_mag      = (div_signed && req_b[W-1]) ? -req_b : req_b;

  // A 2W-bit product of 2W-bit extended operands is exact for both signednesses.
  assign a_ext = {{W{mul_signed_q & a_q[W-1]}}, a_q};
  assign b_ext = {{W{mul_signed_q & b_q[W-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign fix_quo = q_neg_q ? -div_quo : div_quo;
  assign fix_rem = r_neg_q ? -div_rem : div_rem;

  muldiv_div_core #(
    .W (W)
  ) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .abort_i     (kill),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    bad_op_d     = 1'b0;
    mul_cnt_d    = mul_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    mul_signed_d = mul_signed_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    b_zero_d     = b_zero_q;
    div_start    = 1'b0;

    case (state_q)
      StIdle: begin
        // A kill in the accept cycle drops the request entirely.
        if (req_valid && !kill) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              state_d      = StMul;
              mul_cnt_d    = MulCntW'(MUL_STAGES - 1);
              a_d          = req_a;
              b_d          = req_b;
              mul_signed_d = (req_op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d   = StDiv;
              div_start = 1'b1;
              a_d       = req_a;
              b_d       = req_b;
              q_neg_d   = div_signed & (req_a[W-1] ^ req_b[W-1]);
              r_neg_d   = div_signed & req_a[W-1];
              b_zero_d  = (req_b == '0);
            end
            OP_MTHI: hi_d     = req_a;
            OP_MTLO: lo_d     = req_a;
            default: bad_op_d = 1'b1;
          endcase
        end
      end
      StMul: begin
        if (kill) begin
          state_d = StIdle;
        end else if (mul_cnt_q == '0) begin
          state_d = StIdle;
          hi_d    = prod[2*W-1:W];
          lo_d    = prod[W-1:0];
          done_d  = 1'b1;
        end else begin
          mul_cnt_d = mul_cnt_q - 1'b1;
        end
      end
      StDiv: begin
        if (kill) begin
          state_d = StIdle;
        end else if (div_done) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!kill) begin
          done_d = 1'b1;
          if (b_zero_q) begin
            hi_d = a_q;
            lo_d = DIV0_LO[W-1:0];
          end else begin
            hi_d = fix_rem;
            lo_d = fix_quo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hi_q         <= '0;
      lo_q         <= '0;
      done_q       <= 1'b0;
      bad_op_q     <= 1'b0;
      mul_cnt_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      b_zero_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      done_q       <= done_d;
      bad_op_q     <= bad_op_d;
      mul_cnt_q    <= mul_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mul_signed_q <= mul_signed_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      b_zero_q     <= b_zero_d;
    end
  end

endmodule

// File: tb/tb_pipeline_muldiv.sv
// Self-checking bench for pipeline_muldiv: vector table, corner sequences and random ops.
module tb_pipeline_muldiv;

  localparam int W          = 32;
  localparam int MUL_STAGES = 2;
  localparam int DIV_LAT    = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          req_ready;
  logic          kill;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;
  logic          busy;
  logic          done;
  logic          bad_op;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  pipeline_muldiv #(
    .W          (W),
    .MUL_STAGES (MUL_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .kill      (kill),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .done      (done),
    .bad_op    (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen; n is the number of edges taken, -1 if none within the bound.
  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [31:0]     q;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    if (op < 3'd2) return MUL_STAGES;
    ma = (op == 3'd2 && a[31]) ? -a : a;
    mb = (op == 3'd2 && b[31]) ? -b : b;
    if (EarlyOut && (b == 32'd0 || ma < mb)) return 2;
    return DIV_LAT;
  endfunction

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_lat);
    int n;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    step();
    req_valid = 1'b0;
    check({name, " busy"}, 64'(busy), 64'(1));
    wait_done(n);
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " hi"}, 64'(hi_out), 64'(exp_hi));
    check({name, " lo"}, 64'(lo_out), 64'(exp_lo));
    check({name, " idle"}, 64'(busy), 64'(0));
    step();
    check({name, " done pulse"}, 64'(done), 64'(0));
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = h;
    step();
    req_op    = 3'd5;
    req_a     = l;
    step();
    req_valid = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (done) cnt++;
    end
  endtask

  initial begin
    int          n;
    int          cnt;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_STAGES};
    vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL_STAGES};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    vecs[3] = '{3'd3, 32'd7, 32'd2, 32'd1, 32'd3, DIV_LAT};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT};
    vecs[5] = '{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, EarlyOut ? 2 : DIV_LAT};
    vecs[6] = '{3'd3, 32'd3, 32'd10, 32'd3, 32'd0, EarlyOut ? 2 : DIV_LAT};
    vecs[7] = '{3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, DIV_LAT};
    vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, MUL_STAGES};
    vecs[9] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, MUL_STAGES};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = '0;
    req_b     = '0;
    kill      = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("reset hi", 64'(hi_out), 64'(0));
    check("reset lo", 64'(lo_out), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset ready", 64'(req_ready), 64'(1));
    check("reset done", 64'(done), 64'(0));
    check("reset bad_op", 64'(bad_op), 64'(0));

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
            vecs[i].lat);
    end

    // mthi then mtlo back to back.
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'h1234;
    step();
    check("mthi hi", 64'(hi_out), 64'h1234);
    check("mthi no busy", 64'(busy), 64'(0));
    req_op = 3'd5;
    req_a  = 32'h5678;
    step();
    req_valid = 1'b0;
    check("mtlo lo", 64'(lo_out), 64'h5678);
    check("mtlo no done", 64'(done), 64'(0));

    // Request during a running divide is ignored.
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_a     = 32'd100;
    req_b     = 32'd7;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    check("busy ready", 64'(req_ready), 64'(0));
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'hDEAD;
    step();
    req_valid = 1'b0;
    check("ignored mthi", 64'(hi_out), 64'h1234);
    wait_done(n);
    check("ignored lat", 64'(n + 5), 64'(DIV_LAT));
    check("ignored hi", 64'(hi_out), 64'd2);
    check("ignored lo", 64'(lo_out), 64'd14);

    // Kill ten cycles into a divide.
    set_hilo(32'hAAAA, 32'h5555);
    req_valid = 1'b1;
    req_op    = 3'd2;
    req_a     = 32'd1000;
    req_b     = 32'd3;
    step();
    req_valid = 1'b0;
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill10 busy", 64'(busy), 64'(0));
    check("kill10 done", 64'(done), 64'(0));
    count_done(40, cnt);
    check("kill10 no done", 64'(cnt), 64'(0));
    check("kill10 hi", 64'(hi_out), 64'hAAAA);
    check("kill10 lo", 64'(lo_out), 64'h5555);

    // Kill on the result cycle of a multiply and of a divide.
    for (int t = 0; t < 2; t++) begin
      req_valid = 1'b1;
      req_op    = (t == 0) ? 3'd0 : 3'd3;
      req_a     = 32'd100;
      req_b     = 32'd7;
      step();
      req_valid = 1'b0;
      repeat (((t == 0) ? MUL_STAGES : DIV_LAT) - 1) step();
      check($sformatf("killres%0d busy before", t), 64'(busy), 64'(1));
      kill = 1'b1;
      step();
      kill = 1'b0;
      check($sformatf("killres%0d done", t), 64'(done), 64'(0));
      check($sformatf("killres%0d busy", t), 64'(busy), 64'(0));
      check($sformatf("killres%0d hi", t), 64'(hi_out), 64'hAAAA);
      check($sformatf("killres%0d lo", t), 64'(lo_out), 64'h5555);
    end

    // Kill in the accept cycle drops an mthi.
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'hBEEF;
    kill      = 1'b1;
    step();
    req_valid = 1'b0;
    kill      = 1'b0;
    check("kill accept hi", 64'(hi_out), 64'hAAAA);

    // Illegal ops.
    for (int t = 6; t < 8; t++) begin
      req_valid = 1'b1;
      req_op    = 3'(t);
      req_a     = 32'hFFFF;
      req_b     = 32'd1;
      step();
      req_valid = 1'b0;
      check($sformatf("badop%0d pulse", t), 64'(bad_op), 64'(1));
      check($sformatf("badop%0d busy", t), 64'(busy), 64'(0));
      check($sformatf("badop%0d hi", t), 64'(hi_out), 64'hAAAA);
      check($sformatf("badop%0d lo", t), 64'(lo_out), 64'h5555);
      step();
      check($sformatf("badop%0d end", t), 64'(bad_op), 64'(0));
    end

    // Reset in the middle of a divide.
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_a     = 32'd100;
    req_b     = 32'd7;
    step();
    req_valid = 1'b0;
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst hi", 64'(hi_out), 64'(0));
    check("midrst lo", 64'(lo_out), 64'(0));
    check("midrst busy", 64'(busy), 64'(0));
    count_done(40, cnt);
    check("midrst no done", 64'(cnt), 64'(0));

    // Random ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      exp = model(op, a, b);
      do_op($sformatf("rand%0d op%0d", i, op), op, a, b, exp[63:32], exp[31:0],
            lat_of(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
